// File: rtl/svfloat_itof_pipe.sv
// Three-stage integer to float converter, round to nearest even.
// Valid/ready on both sides; S1 sign/magnitude, S2 normalize, S3 round/pack.
module svfloat_msb #(
  parameter int width = 32,
  parameter int msb_w = $clog2(width)
) (
  input  logic [width-1:0] mag,
  output logic [msb_w-1:0] msb
);
  always_comb begin
    msb = '0;
    for (int i = 0; i < width; i++) begin
      if (mag[i]) msb = msb_w'(i);
    end
  end
endmodule

module svfloat_itof_pipe #(
  parameter int width     = 32,
  parameter int exp_w     = 8,
  parameter int man_w     = 23,
  parameter bit signed_in = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [width-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [exp_w+man_w:0]     out_data,
  output logic                     out_inexact
);
  localparam int msb_w = $clog2(width);
  localparam int ex_w  = ((exp_w > msb_w) ? exp_w : msb_w) + 2;
  localparam int xw    = width + man_w;
  localparam logic [ex_w-1:0] bias = ex_w'((2 ** (exp_w - 1)) - 1);
  localparam logic [ex_w-1:0] emax = ex_w'((2 ** exp_w) - 1);

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic [width-1:0] mag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic [msb_w-1:0] msb;
    logic [width-1:0] norm;
  } s2_t;

  logic v1, v2, v3;
  logic ld1, ld2, ld3;
  logic acc;
  s1_t  s1, s1_d;
  s2_t  s2, s2_d;

  assign out_valid = v3;
  assign ld3 = !v3 || out_ready;
  assign ld2 = !v2 || ld3;
  assign ld1 = !v1 || ld2;
  assign in_ready = !rst && ld1;
  assign acc = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (ld1) v1 <= acc;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
    end
  end

  // S1: two's complement magnitude; the most negative value stays unsigned
  always_comb begin
    s1_d.sign = signed_in && in_data[width-1];
    s1_d.mag  = s1_d.sign ? (~in_data + 1'b1) : in_data;
    s1_d.zero = (s1_d.mag == '0);
  end

  logic [msb_w-1:0] msb;
  logic [msb_w-1:0] shamt;

  svfloat_msb #(.width(width), .msb_w(msb_w)) u_msb (
    .mag (s1.mag),
    .msb (msb)
  );

  assign shamt = msb_w'(width - 1) - msb;

  always_comb begin
    s2_d.sign = s1.sign;
    s2_d.zero = s1.zero;
    s2_d.msb  = msb;
    s2_d.norm = s1.mag << shamt;
  end

  // S3: fraction below the leading one, zero padded so the window always fits
  logic [xw-1:0]          ext;
  logic [man_w-1:0]       mant;
  logic                   guard;
  logic                   sticky;
  logic                   rnd;
  logic [man_w:0]         mant_r;
  logic [ex_w-1:0]        ex;
  logic                   ovf;
  logic [exp_w+man_w:0]   res;
  logic                   res_x;

  always_comb begin
    ext    = {s2.norm[width-2:0], {(man_w + 1){1'b0}}};
    mant   = ext[xw-1 -: man_w];
    guard  = ext[xw-1-man_w];
    sticky = |ext[xw-2-man_w:0];
    rnd    = guard && (sticky || mant[0]);
    mant_r = {1'b0, mant} + (man_w + 1)'(rnd);
    ex     = bias + ex_w'(s2.msb) + ex_w'(mant_r[man_w]);
    ovf    = (ex >= emax);
    res    = {s2.sign, ex[exp_w-1:0], mant_r[man_w-1:0]};
    res_x  = guard || sticky;
    if (s2.zero) begin
      res   = '0;
      res_x = 1'b0;
    end else if (ovf) begin
      res   = {s2.sign, {exp_w{1'b1}}, {man_w{1'b0}}};
      res_x = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) s1 <= s1_d;
    if (ld2 && v1) s2 <= s2_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data    <= '0;
      out_inexact <= 1'b0;
    end else if (ld3 && v2) begin
      out_data    <= res;
      out_inexact <= res_x;
    end
  end
endmodule

// File: tb/tb_svfloat_itof_pipe.sv
// Bench for svfloat_itof_pipe: directed tables, handshake corners,
// and random traffic against an arithmetic reference model.
module tb_svfloat_itof_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_inexact;
  logic [31:0] in_data, out_data;

  logic        in_valid_u, in_ready_u, out_valid_u, out_inexact_u;
  logic [31:0] in_data_u;
  logic [15:0] out_data_u;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  svfloat_itof_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_inexact(out_inexact)
  );

  svfloat_itof_pipe #(.width(32), .exp_w(5), .man_w(10), .signed_in(1'b0)) dut_u (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_u), .in_ready(in_ready_u), .in_data(in_data_u),
    .out_valid(out_valid_u), .out_ready(1'b1),
    .out_data(out_data_u), .out_inexact(out_inexact_u)
  );

  typedef struct {
    logic [31:0] d;
    logic        x;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic        x;
    int          c;
  } obs_t;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    logic        x;
  } vec_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  obs_t obs_u[$];
  int   acc_c[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, want);
    end
  endtask

  // Value-level reference: exact remainder compared against half an ulp
  function automatic void ref_conv(input logic [31:0] v, input int w, input int ew,
                                   input int mw, input bit sg,
                                   output logic [31:0] res, output logic inex);
    longint unsigned mag, q, r, half;
    int e, sh;
    longint unsigned sgn;
    sgn = 0;
    mag = 64'(v);
    if (sg && v[w-1]) begin
      sgn = 1;
      mag = (64'd1 << w) - mag;
    end
    res = '0;
    inex = 1'b0;
    if (mag == 0) return;
    e = 63;
    while (mag[e] == 1'b0) e--;
    if (e <= mw) begin
      q = mag << (mw - e);
    end else begin
      sh = e - mw;
      q = mag >> sh;
      r = mag & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (r > half || (r == half && q[0])) q++;
      inex = (r != 0);
      if ((q >> (mw + 1)) != 0) begin
        q = q >> 1;
        e++;
      end
    end
    if (longint'((1 << (ew - 1)) - 1 + e) >= longint'((1 << ew) - 1)) begin
      res = 32'((sgn << (ew + mw)) | (((64'd1 << ew) - 1) << mw));
      inex = 1'b1;
    end else begin
      res = 32'((sgn << (ew + mw)) | (64'((1 << (ew - 1)) - 1 + e) << mw)
                | (q & ((64'd1 << mw) - 1)));
    end
  endfunction

  logic [31:0] m_res;
  logic        m_x;
  exp_t        m_e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        ref_conv(in_data, 32, 8, 23, 1'b1, m_res, m_x);
        exp_q.push_back('{d: m_res, x: m_x});
        acc_c.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        obs_q.push_back('{d: out_data, x: out_inexact, c: cyc});
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 64'(out_data), 64'hDEAD);
        end else begin
          m_e = exp_q.pop_front();
          chk("sb_data", 64'(out_data), 64'(m_e.d));
          chk("sb_inexact", 64'(out_inexact), 64'(m_e.x));
        end
      end
    end
    if (!rst && out_valid_u)
      obs_u.push_back('{d: 32'(out_data_u), x: out_inexact_u, c: cyc});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [31:0] v);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data = v;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("drive_timeout", 64'd0, 64'd1);
  endtask

  vec_t tab[$];
  vec_t tab_u[$];
  logic [31:0] bp_w[5];
  logic [31:0] hold;
  logic [31:0] rv;
  int acc;
  int idx;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    in_valid_u = 1'b0;
    in_data_u = '0;

    tab = '{
      '{32'h00000001, 32'h3F800000, 1'b0},
      '{32'hFFFFFFFF, 32'hBF800000, 1'b0},
      '{32'h00000000, 32'h00000000, 1'b0},
      '{32'h01000001, 32'h4B800000, 1'b1},
      '{32'h01000003, 32'h4B800002, 1'b1},
      '{32'h7FFFFFFF, 32'h4F000000, 1'b1},
      '{32'h80000000, 32'hCF000000, 1'b0},
      '{32'h00FFFFFF, 32'h4B7FFFFF, 1'b0}
    };
    tab_u = '{
      '{32'h00000001, 32'h00003C00, 1'b0},
      '{32'hFFFFFFFF, 32'h00007C00, 1'b1},
      '{32'h0000FFF0, 32'h00007C00, 1'b1},
      '{32'h0000FFE0, 32'h00007BFF, 1'b0},
      '{32'h00000800, 32'h00006800, 1'b0},
      '{32'h00000000, 32'h00000000, 1'b0},
      '{32'h00000003, 32'h00004200, 1'b0},
      '{32'h00001001, 32'h00006C00, 1'b1}
    };

    // reset: input offered during rst must be refused
    tick();
    in_valid = 1'b1;
    in_data = 32'd5;
    @(negedge clk);
    chk("rst_in_ready_low", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_inexact", 64'(out_inexact), 64'd0);
    tick();

    // directed table, back to back, full throughput
    obs_q.delete();
    acc_c.delete();
    foreach (tab[i]) drive_word(tab[i].din);
    repeat (6) tick();
    chk("tab_count", 64'(obs_q.size()), 64'(tab.size()));
    if (obs_q.size() == tab.size()) begin
      foreach (tab[i]) begin
        chk($sformatf("tab_data_%0d", i), 64'(obs_q[i].d), 64'(tab[i].dout));
        chk($sformatf("tab_inexact_%0d", i), 64'(obs_q[i].x), 64'(tab[i].x));
      end
      chk("latency", 64'(obs_q[0].c - acc_c[0]), 64'd3);
      for (int i = 1; i < 3; i++)
        chk("tab_consecutive", 64'(obs_q[i].c - obs_q[0].c), 64'(i));
    end

    // backpressure: capacity 3, stable output while stalled
    obs_q.delete();
    for (int i = 0; i < 5; i++) bp_w[i] = 32'h100 * (i + 1) + 32'd7;
    out_ready = 1'b0;
    acc = 0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data = bp_w[idx];
      @(negedge clk);
      if (in_ready) begin
        acc++;
        idx++;
      end
      tick();
    end
    chk("bp_accepted", 64'(acc), 64'd3);
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    hold = out_data;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stable", 64'(out_data), 64'(hold));
    end
    tick();
    out_ready = 1'b1;
    for (int i = idx; i < 5; i++) drive_word(bp_w[i]);
    repeat (8) tick();
    chk("bp_count", 64'(obs_q.size()), 64'd5);
    if (obs_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        ref_conv(bp_w[i], 32, 8, 23, 1'b1, m_res, m_x);
        chk("bp_order", 64'(obs_q[i].d), 64'(m_res));
        chk("bp_no_gap", 64'(obs_q[i].c - obs_q[0].c), 64'(i));
      end
    end

    // reset with words in flight
    out_ready = 1'b0;
    drive_word(32'd11);
    drive_word(32'd22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    obs_q.delete();
    out_ready = 1'b1;
    repeat (8) tick();
    chk("mid_rst_no_output", 64'(obs_q.size()), 64'd0);

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      case ($urandom % 4)
        0: rv = $urandom;
        1: rv = $urandom >> ($urandom % 32);
        2: rv = -($urandom % 1000);
        default: rv = (32'd1 << ($urandom % 31)) | ($urandom % 4);
      endcase
      in_valid = ($urandom % 4) != 0;
      in_data = rv;
      out_ready = ($urandom % 4) != 0;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    // narrow unsigned format with overflow to infinity
    obs_u.delete();
    foreach (tab_u[i]) begin
      in_valid_u = 1'b1;
      in_data_u = tab_u[i].din;
      tick();
    end
    in_valid_u = 1'b0;
    repeat (6) tick();
    chk("u_count", 64'(obs_u.size()), 64'(tab_u.size()));
    if (obs_u.size() == tab_u.size()) begin
      foreach (tab_u[i]) begin
        ref_conv(tab_u[i].din, 32, 5, 10, 1'b0, m_res, m_x);
        chk($sformatf("u_model_%0d", i), 64'(m_res), 64'(tab_u[i].dout));
        chk($sformatf("u_data_%0d", i), 64'(obs_u[i].d), 64'(tab_u[i].dout));
        chk($sformatf("u_inexact_%0d", i), 64'(obs_u[i].x), 64'(tab_u[i].x));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/svfloat_itof_pipe.md
Name: svfloat_itof_pipe

Overview:
Pipelined integer-to-float converter with a valid/ready handshake on both sides. It takes signed or unsigned integers and produces packed sign/exponent/mantissa floats, rounded to nearest, ties to even. Stage 2 instantiates svfloat_msb to locate the leading one, then normalizes on that index. It sits at the front of the float datapath and feeds the arithmetic units.

Parameters:
width, 32, integer input width (>= 2)
exp_w, 8, exponent field width
man_w, 23, stored mantissa width (hidden bit excluded)
signed_in, 1, 1 = input is two's complement, 0 = input is unsigned

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input word present
in_ready  out  1  block accepts input this cycle
in_data  in  width  integer to convert
out_valid  out  1  result present
out_ready  in  1  consumer accepts result this cycle
out_data  out  1+exp_w+man_w  packed result {sign, exponent, mantissa}
out_inexact  out  1  result was rounded or overflowed

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous, active-high.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Three stages, S1, S2, S3, each with a valid bit. Latency from input transfer to out_valid is exactly 3 cycles when not stalled.
- Stage advance: a stage loads when the stage after it is empty or is itself advancing.
  - in_ready = !s1_valid || s1_advance.
  - S3 advances on out_ready.
  - Full throughput is 1 word/cycle with out_ready held high.
  - Bubbles collapse: an empty downstream stage never blocks an upstream one.
- Stall: while out_valid && !out_ready, out_data and out_inexact hold stable. No word is lost or duplicated. Pipeline capacity is 3 words.
- S1, sign and magnitude:
  - If signed_in and in_data[width-1] is set: sign = 1 and mag = -in_data, taken as an unsigned width-bit value. The most negative input gives mag = 2^(width-1).
  - Otherwise: sign = 0 and mag = in_data.
  - Register zero flag = (mag == 0).
- S2, normalize:
  - msb = svfloat_msb(mag).
  - norm = mag << (width-1-msb), which places the leading one at bit width-1.
  - Register sign, zero, msb, norm.
- S3, round and pack:
  - mant = norm[width-2 -: man_w]. The window is zero-padded below bit 0 when width-1 < man_w.
  - guard = the bit just below the mant window.
  - sticky = OR of all bits below guard.
  - guard and sticky are 0 if no such bits exist.
  - Round up iff guard && (sticky || mant[0]).
  - A mantissa carry-out (all ones + 1) clears mant and adds 1 to the exponent.
  - exponent = (2^(exp_w-1)-1) + msb + carry, computed at sufficient width with no truncation.
  - exponent >= 2^exp_w-1 → infinity: exponent all ones, mant = 0, out_inexact = 1.
  - Zero input → {sign=0, 0, 0}, out_inexact = 0. Negative zero is never produced.
  - out_inexact = guard || sticky || overflow.
- Reset:
  - All stage valid bits clear, so out_valid = 0.
  - out_data = 0, out_inexact = 0, in_ready = 1 in the cycle after rst.
  - Reset mid-operation discards all in-flight words.
  - Inputs presented while rst is high are not accepted.

Test Plan:
- Defaults throughout (width=32, exp_w=8, man_w=23, signed_in=1).
- Inputs 1, then 0xFFFFFFFF, then 0, back-to-back with out_ready=1 → outputs 0x3F800000, 0xBF800000, 0x00000000 on 3 consecutive cycles, first one 3 cycles after input. out_inexact=0 for all three.
- Tie rounding: 0x01000001 → 0x4B800000, inexact=1 (tie, rounds to even, down). 0x01000003 → 0x4B800002, inexact=1 (tie, rounds up).
- Carry and extremes: 0x7FFFFFFF → 0x4F000000, inexact=1 (mantissa carry bumps exponent). 0x80000000 → 0xCF000000, inexact=0.
- Overflow: with signed_in=0, width=32, exp_w=5, man_w=10, input 0xFFFFFFFF → 0x7C00, inexact=1.
- Backpressure: out_ready=0 while 5 words are offered back-to-back → exactly 3 accepted, then in_ready=0 and out_data stable. Release out_ready → 5 results appear in order, no gaps once flowing.
- Reset mid-operation: assert rst for 1 cycle with 2 words in flight → out_valid=0 and in_ready=1 the next cycle, and the pre-reset words are never output.
